fp32_vec_scaler: RTL and testbench
==================================

Name: fp32_vec_scaler

Overview:
Parametrised, pipelined IEEE-754 single-precision vector scaler for the Jacobi rotation datapath. Multiplies every lane of a CH-lane vector by a runtime-programmable scale factor (default 2.0) and adds valid/ready flow control, exception flags and an in-flight count. Sits between the matrix-element fetch stage and the rotation-update stage, replacing fixed-constant multiplier instances.

Parameters:
CH, 5, number of FP32 lanes per vector (1..16)
PIPE, 3, pipeline depth in cycles from accept to out_valid (1..6)
SCALE_DEFAULT, 32'h40000000, scale register value after reset (2.0)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
scale_we  input  1  write strobe for scale register
scale_in  input  32  new FP32 scale value
in_valid  input  1  input vector valid
in_ready  output  1  block can accept vector this cycle
in_data  input  CH*32  lane k at bits [32k+31:32k]
out_valid  output  1  output vector valid
out_ready  input  1  downstream accepts output
out_data  output  CH*32  scaled lanes, same packing
out_ovf  output  1  OR over lanes: result overflowed to infinity
out_inv  output  1  OR over lanes: invalid operation (NaN operand or inf*0)
inflight  output  $clog2(PIPE+1)  vectors currently held in pipeline

Behaviour:
- Reset (reset=0, async): out_valid=0, out_data=0, out_ovf=0, out_inv=0, inflight=0, scale=SCALE_DEFAULT, all stage valids cleared. Reset mid-operation discards all in-flight vectors; nothing emitted after release until a new accept.
- Accept when in_valid && in_ready; emit when out_valid && out_ready.
- Stall-all pipeline: advance = !out_valid || out_ready; in_ready = advance (combinational from out_ready). Whole pipe freezes when advance=0; out_data/flags hold stable while out_valid && !out_ready.
- Latency exactly PIPE cycles with no backpressure; throughput one vector/cycle; bubbles propagate as invalid stages, not collapsed.
- Scale: scale_we writes on clk edge at any time. Vector accepted in same cycle as write uses OLD scale; vectors accepted later use new scale. Scale is captured per vector at stage 0 and travels with it.
- inflight: +1 on accept, -1 on emit, unchanged when both or neither; never exceeds PIPE.
- Arithmetic per lane: sign = sa^sb; 24x24 mantissa product; round-to-nearest-even; denormal inputs treated as signed zero; underflowing/denormal results flushed to signed zero (no flag); exponent overflow -> signed infinity, ovf=1; finite*inf -> signed infinity (ovf=0); NaN operand or 0*inf -> 0x7FC00000, inv=1.
- Flags are per-vector, registered alongside out_data, not sticky.

Decomposition:
- Package jacobi_fp_pkg: FP32_W=32, EXP_W=8, MAN_W=23, EXP_BIAS=127, FP_QNAN=32'h7FC00000, FP_TWO=32'h40000000, FP_PINF=32'h7F800000.
- Sub-module fp32_mul_pipe: one lane, PIPE stages, shared advance enable, outputs result+ovf+inv; instantiated CH times via generate. Top owns scale register, valid chain, inflight counter, flag reduction.

Test Plan:
- Reset default scale, lane0=0x40400000 (3.0), lane1=0xBF800000 (-1.0) -> after 3 cycles lane0=0x40C00000, lane1=0xC0000000, ovf=inv=0, inflight 1 then 0.
- scale_we 0x3F000000 (0.5) same cycle as accept of 0x3FC00000, next cycle accept 0x3FC00000 -> outputs 0x40400000 then 0x3F400000.
- Lane 0x7F7FFFFF scale 2.0 -> 0x7F800000, ovf=1; lane 0x7F800000 scale 0x00000000 -> 0x7FC00000, inv=1; lane 0x00000001 -> 0x00000000, no flag.
- Streaming 8 vectors, out_ready low cycles 4-6 -> in_ready low same cycles, out_data stable, all 8 emitted in order, none lost/duplicated, inflight max 3.
- Reset asserted with 3 vectors in flight -> out_valid=0 immediately, inflight=0, scale=0x40000000, no emission after release.
- Rounding: 0x3F800001 * 0x3F800001 -> 0x3F800002 (RNE tie/carry check).

Source files
------------

// File: rtl/jacobi_fp_pkg.sv
// Shared FP32 constants, the per-lane result payload and the single-cycle
// IEEE-754 multiply function used by the Jacobi rotation datapath.
package jacobi_fp_pkg;

    localparam int unsigned FP32_W   = 32;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MAN_W    = 23;
    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned PROD_W   = 2 * MAN_W + 2;
    localparam int unsigned SEXP_W   = EXP_W + 2;

    localparam logic [FP32_W-1:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [FP32_W-1:0] FP_TWO  = 32'h4000_0000;
    localparam logic [FP32_W-1:0] FP_PINF = 32'h7F80_0000;

    localparam logic signed [SEXP_W-1:0] SEXP_MAX = SEXP_W'((1 << EXP_W) - 1);

    typedef struct packed {
        logic [FP32_W-1:0] res;
        logic              ovf;
        logic              inv;
    } fp_res_t;

    // RNE multiply; denormal operands read as zero, tiny results flush to signed zero.
    function automatic fp_res_t fp32_mul(input logic [FP32_W-1:0] a,
                                         input logic [FP32_W-1:0] b);
        fp_res_t                  r;
        logic                     sgn;
        logic [EXP_W-1:0]         ea, eb;
        logic [MAN_W-1:0]         ma, mb, frac;
        logic                     a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        logic [PROD_W-1:0]        prod;
        logic                     guard, sticky;
        logic [MAN_W+1:0]         mr;
        logic signed [SEXP_W-1:0] e;

        sgn    = a[FP32_W-1] ^ b[FP32_W-1];
        ea     = a[MAN_W +: EXP_W];
        eb     = b[MAN_W +: EXP_W];
        ma     = a[MAN_W-1:0];
        mb     = b[MAN_W-1:0];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == '1) && (ma == '0);
        b_inf  = (eb == '1) && (mb == '0);
        a_nan  = (ea == '1) && (ma != '0);
        b_nan  = (eb == '1) && (mb != '0);

        prod = PROD_W'({1'b1, ma}) * PROD_W'({1'b1, mb});
        e    = SEXP_W'(ea) + SEXP_W'(eb) - SEXP_W'(EXP_BIAS);

        // Product is in [1,4): normalise by one bit when the top bit is set.
        if (prod[PROD_W-1]) begin
            frac   = prod[PROD_W-2 -: MAN_W];
            guard  = prod[PROD_W-2-MAN_W];
            sticky = |prod[PROD_W-3-MAN_W:0];
            e      = e + SEXP_W'(1);
        end else begin
            frac   = prod[PROD_W-3 -: MAN_W];
            guard  = prod[PROD_W-3-MAN_W];
            sticky = |prod[PROD_W-4-MAN_W:0];
        end

        mr = {2'b01, frac} + (MAN_W+2)'(guard & (sticky | frac[0]));
        if (mr[MAN_W+1]) begin
            e    = e + SEXP_W'(1);
            frac = '0;
        end else begin
            frac = mr[MAN_W-1:0];
        end

        r = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            r.res = FP_QNAN;
            r.inv = 1'b1;
        end else if (a_inf || b_inf) begin
            r.res = {sgn, FP_PINF[FP32_W-2:0]};
        end else if (a_zero || b_zero) begin
            r.res = {sgn, (FP32_W-1)'(0)};
        end else if (e >= SEXP_MAX) begin
            r.res = {sgn, FP_PINF[FP32_W-2:0]};
            r.ovf = 1'b1;
        end else if (e <= 0) begin
            r.res = {sgn, (FP32_W-1)'(0)};
        end else begin
            r.res = {sgn, e[EXP_W-1:0], frac};
        end
        return r;
    endfunction

endpackage

// File: rtl/fp32_vec_scaler_if.sv
// Stream, scale-programming and status signals of the FP32 vector scaler.
interface fp32_vec_scaler_if #(
    parameter int unsigned CH   = 5,
    parameter int unsigned PIPE = 3
);
    localparam int unsigned CNT_W = $clog2(PIPE + 1);

    logic                 scale_we;
    logic [31:0]          scale_in;
    logic                 in_valid;
    logic                 in_ready;
    logic [CH*32-1:0]     in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [CH*32-1:0]     out_data;
    logic                 out_ovf;
    logic                 out_inv;
    logic [CNT_W-1:0]     inflight;

    modport master (
        output scale_we, scale_in, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_inv, inflight
    );

    modport slave (
        input  scale_we, scale_in, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_inv, inflight
    );
endinterface

// File: rtl/fp32_mul_pipe.sv
// One FP32 multiplier lane: product computed at entry, then carried through
// PIPE stall-able stages sharing the vector-wide advance enable.
module fp32_mul_pipe
    import jacobi_fp_pkg::*;
#(
    parameter int unsigned PIPE = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv_i,
    input  logic [FP32_W-1:0] a_i,
    input  logic [FP32_W-1:0] b_i,
    output logic [FP32_W-1:0] res_o,
    output logic              ovf_o,
    output logic              inv_o
);

    fp_res_t stage_q [PIPE];
    fp_res_t stage_d [PIPE];

    always_comb begin
        stage_d[0] = fp32_mul(a_i, b_i);
        for (int i = 1; i < int'(PIPE); i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(PIPE); i++) begin
                stage_q[i] <= '0;
            end
        end else if (adv_i) begin
            stage_q <= stage_d;
        end
    end

    assign res_o = stage_q[PIPE-1].res;
    assign ovf_o = stage_q[PIPE-1].ovf;
    assign inv_o = stage_q[PIPE-1].inv;

endmodule

// File: rtl/fp32_vec_scaler.sv
// CH-lane FP32 vector scaler: programmable scale register, stall-all valid
// chain, in-flight counter and per-vector exception flag reduction.
module fp32_vec_scaler
    import jacobi_fp_pkg::*;
#(
    parameter int unsigned       CH            = 5,
    parameter int unsigned       PIPE          = 3,
    parameter logic [FP32_W-1:0] SCALE_DEFAULT = FP_TWO
) (
    input  logic              clk,
    input  logic              reset,
    fp32_vec_scaler_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(PIPE + 1);

    logic [FP32_W-1:0] scale_q, scale_d;
    logic [PIPE-1:0]   vld_q, vld_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic              advance, accept, emit;
    logic [FP32_W-1:0] lane_res [CH];
    logic [CH-1:0]     lane_ovf, lane_inv;

    assign advance = !vld_q[PIPE-1] || bus.out_ready;
    assign accept  = bus.in_valid && advance;
    assign emit    = vld_q[PIPE-1] && bus.out_ready;

    // Scale write lands after the edge, so a same-cycle accept sees the old value.
    always_comb begin
        scale_d    = bus.scale_we ? bus.scale_in : scale_q;
        vld_d      = vld_q;
        inflight_d = inflight_q;
        if (advance) begin
            vld_d[0] = accept;
            for (int i = 1; i < int'(PIPE); i++) begin
                vld_d[i] = vld_q[i-1];
            end
        end
        if (accept && !emit) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!accept && emit) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scale_q    <= SCALE_DEFAULT;
            vld_q      <= '0;
            inflight_q <= '0;
        end else begin
            scale_q    <= scale_d;
            vld_q      <= vld_d;
            inflight_q <= inflight_d;
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_lane
        fp32_mul_pipe #(.PIPE(PIPE)) u_mul (
            .clk   (clk),
            .rst_n (reset),
            .adv_i (advance),
            .a_i   (bus.in_data[FP32_W*k +: FP32_W]),
            .b_i   (scale_q),
            .res_o (lane_res[k]),
            .ovf_o (lane_ovf[k]),
            .inv_o (lane_inv[k])
        );
    end

    always_comb begin
        bus.out_data = '0;
        for (int k = 0; k < int'(CH); k++) begin
            bus.out_data[FP32_W*k +: FP32_W] = lane_res[k];
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = vld_q[PIPE-1];
    assign bus.out_ovf   = |lane_ovf;
    assign bus.out_inv   = |lane_inv;
    assign bus.inflight  = inflight_q;

endmodule

// File: tb/tb_fp32_vec_scaler.sv
// Directed scoreboard bench for fp32_vec_scaler (CH=5, PIPE=3).
module tb_fp32_vec_scaler;

    localparam int unsigned CH   = 5;
    localparam int unsigned PIPE = 3;
    localparam int unsigned DW   = CH * 32;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          ovf;
        logic          inv;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    fp32_vec_scaler_if #(.CH(CH), .PIPE(PIPE)) bus ();

    fp32_vec_scaler #(
        .CH            (CH),
        .PIPE          (PIPE),
        .SCALE_DEFAULT (32'h4000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t sb [$];
    int   checks    = 0;
    int   fails     = 0;
    int   emitted   = 0;
    int   max_infl  = 0;
    logic last_in_ready;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] want);
        checks++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    function automatic logic [DW-1:0] vec(input logic [31:0] l0, input logic [31:0] l1,
                                          input logic [31:0] l2, input logic [31:0] l3,
                                          input logic [31:0] l4);
        return {l4, l3, l2, l1, l0};
    endfunction

    function automatic exp_t ex(input logic [DW-1:0] d, input logic ovf, input logic inv);
        exp_t e;
        e.d   = d;
        e.ovf = ovf;
        e.inv = inv;
        return e;
    endfunction

    // Streaming operands: scaling by 2.0 only bumps the exponent field.
    function automatic logic [DW-1:0] svec(input int i, input int bump);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < int'(CH); k++) begin
            r[32*k +: 32] = {1'((i + k) & 1), 8'(100 + 3*i + k + bump), 23'(i*4099 + k*77 + 1)};
        end
        return r;
    endfunction

    // One clock: drive at the falling edge, check/score before the rising edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input exp_t e,
                         input logic ordy, input logic we, input logic [31:0] sc,
                         output logic acc);
        exp_t got;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.scale_we  = we;
        bus.scale_in  = sc;
        #1;
        chk("inflight_vs_scoreboard", DW'(bus.inflight), DW'(sb.size()));
        chk("in_ready_rule", DW'(bus.in_ready), DW'(!bus.out_valid || ordy));
        last_in_ready = bus.in_ready;
        if (int'(bus.inflight) > max_infl) max_infl = int'(bus.inflight);
        if (bus.out_valid && ordy) begin
            if (sb.size() == 0) begin
                chk("spurious_emit", DW'(bus.out_valid), DW'(0));
            end else begin
                got = sb.pop_front();
                chk("out_data", bus.out_data, got.d);
                chk("out_ovf", DW'(bus.out_ovf), DW'(got.ovf));
                chk("out_inv", DW'(bus.out_inv), DW'(got.inv));
                emitted++;
            end
        end
        acc = v && bus.in_ready;
        if (acc) sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input logic we, input logic [31:0] sc);
        logic a;
        cycle(1'b0, '0, '0, 1'b1, we, sc, a);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1'b0, '0);
        chk("drain_empty", DW'(sb.size()), DW'(0));
        idle(1'b0, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          acc;
        logic          snap_ov;
        logic [DW-1:0] snap_od;
        logic          ordy;
        int            n, c, base;

        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.scale_we  = 1'b0;
        bus.scale_in  = '0;
        repeat (3) @(negedge clk);

        chk("rst_out_valid", DW'(bus.out_valid), DW'(0));
        chk("rst_out_data", bus.out_data, DW'(0));
        chk("rst_out_ovf", DW'(bus.out_ovf), DW'(0));
        chk("rst_out_inv", DW'(bus.out_inv), DW'(0));
        chk("rst_inflight", DW'(bus.inflight), DW'(0));
        reset = 1'b1;
        @(negedge clk);

        // Default scale 2.0 and exact PIPE-cycle latency.
        cycle(1'b1, vec(32'h4040_0000, 32'hBF80_0000, 0, 0, 0),
              ex(vec(32'h40C0_0000, 32'hC000_0000, 0, 0, 0), 1'b0, 1'b0),
              1'b1, 1'b0, '0, acc);
        chk("t1_accept", DW'(acc), DW'(1));
        chk("t1_valid_c1", DW'(bus.out_valid), DW'(0));
        chk("t1_inflight_1", DW'(bus.inflight), DW'(1));
        idle(1'b0, '0);
        chk("t1_valid_c2", DW'(bus.out_valid), DW'(0));
        idle(1'b0, '0);
        chk("t1_valid_c3", DW'(bus.out_valid), DW'(1));
        idle(1'b0, '0);
        chk("t1_valid_after", DW'(bus.out_valid), DW'(0));
        chk("t1_inflight_0", DW'(bus.inflight), DW'(0));
        chk("t1_emitted", DW'(emitted), DW'(1));

        // Scale write in the accept cycle applies only to later vectors.
        cycle(1'b1, vec(32'h3FC0_0000, 0, 0, 0, 0),
              ex(vec(32'h4040_0000, 0, 0, 0, 0), 1'b0, 1'b0), 1'b1, 1'b1, 32'h3F00_0000, acc);
        cycle(1'b1, vec(32'h3FC0_0000, 0, 0, 0, 0),
              ex(vec(32'h3F40_0000, 0, 0, 0, 0), 1'b0, 1'b0), 1'b1, 1'b0, '0, acc);
        drain();

        // Exceptions at scale 2.0.
        idle(1'b1, 32'h4000_0000);
        cycle(1'b1, vec(32'h7F7F_FFFF, 32'h0000_0001, 32'h7F80_0000, 32'hFF80_0000, 32'h3F80_0000),
              ex(vec(32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h4000_0000), 1'b1, 1'b0),
              1'b1, 1'b0, '0, acc);
        cycle(1'b1, vec(32'h0000_0001, 32'h8000_0001, 0, 0, 0),
              ex(vec(0, 32'h8000_0000, 0, 0, 0), 1'b0, 1'b0), 1'b1, 1'b0, '0, acc);
        cycle(1'b1, vec(32'h7FC1_2345, 32'hFF80_0001, 0, 0, 0),
              ex(vec(32'h7FC0_0000, 32'h7FC0_0000, 0, 0, 0), 1'b0, 1'b1), 1'b1, 1'b0, '0, acc);
        drain();

        // inf * 0 is invalid; finite * 0 keeps the product sign.
        idle(1'b1, 32'h0000_0000);
        cycle(1'b1, vec(32'h7F80_0000, 32'h4000_0000, 32'hC000_0000, 32'h0000_0001, 0),
              ex(vec(32'h7FC0_0000, 0, 32'h8000_0000, 0, 0), 1'b0, 1'b1), 1'b1, 1'b0, '0, acc);
        drain();

        // Round-to-nearest-even with one-ulp operands.
        idle(1'b1, 32'h3F80_0001);
        cycle(1'b1, vec(32'h3F80_0001, 32'h3F80_0000, 32'h4000_0000, 0, 0),
              ex(vec(32'h3F80_0002, 32'h3F80_0001, 32'h4000_0001, 0, 0), 1'b0, 1'b0),
              1'b1, 1'b0, '0, acc);
        drain();

        // Streaming with a three-cycle downstream stall.
        idle(1'b1, 32'h4000_0000);
        max_infl = 0;
        base     = emitted;
        n        = 0;
        c        = 0;
        while ((n < 8 || sb.size() != 0) && c < 40) begin
            ordy    = !(c >= 4 && c <= 6);
            snap_ov = bus.out_valid;
            snap_od = bus.out_data;
            cycle(n < 8, svec(n, 0), ex(svec(n, 1), 1'b0, 1'b0), ordy, 1'b0, '0, acc);
            if (acc) n++;
            if (c >= 4 && c <= 6) begin
                chk("stall_in_ready", DW'(last_in_ready), DW'(0));
                chk("stall_valid_hold", DW'(bus.out_valid), DW'(1));
                chk("stall_data_hold", bus.out_data, snap_od);
            end
            if (snap_ov && !ordy && !(c >= 4 && c <= 6)) begin
                chk("unexpected_stall", DW'(snap_ov), DW'(0));
            end
            c++;
        end
        chk("stream_emitted", DW'(emitted - base), DW'(8));
        chk("stream_max_inflight", DW'(max_infl), DW'(3));
        idle(1'b0, '0);

        // Reset with three vectors in flight discards them and restores scale.
        idle(1'b1, 32'h3F00_0000);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, vec(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000),
                  ex(vec(32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000), 1'b0, 1'b0),
                  1'b0, 1'b0, '0, acc);
        end
        chk("mid_inflight_3", DW'(bus.inflight), DW'(3));
        chk("mid_valid", DW'(bus.out_valid), DW'(1));
        bus.in_valid = 1'b0;
        reset        = 1'b0;
        #1;
        chk("arst_out_valid", DW'(bus.out_valid), DW'(0));
        chk("arst_inflight", DW'(bus.inflight), DW'(0));
        chk("arst_out_data", bus.out_data, DW'(0));
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) idle(1'b0, '0);
        chk("post_rst_no_emit", DW'(bus.out_valid), DW'(0));
        cycle(1'b1, vec(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000),
              ex(vec(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000), 1'b0, 1'b0),
              1'b1, 1'b0, '0, acc);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
